// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free start/stop and wrap-synchronised reload.
// Optional edge strobes are enabled by defining CLK_DIV_PROG_STROBE_EN.
module clk_div_prog #(
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] hi_in,
  input  logic             load,
  output logic             load_ack,
  output logic             busy,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] RST_H = WIDTH'(RESET_DIV / 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] pdiv_q,  pdiv_d;
  logic [WIDTH-1:0] phi_q,   phi_d;
  logic             pend_q,  pend_d;
  logic             clk_q,   clk_d;
  logic             ack_q,   ack_d;

  logic [WIDTH-1:0] san_div;
  logic [WIDTH-1:0] san_hi;
  logic             wrap;

  // Clamp requests so the output always toggles.
  always_comb begin
    san_div = div_in;
    if (div_in < TWO) begin
      san_div = TWO;
    end
    san_hi = hi_in;
    if (hi_in == '0) begin
      san_hi = ONE;
    end else if (hi_in >= san_div) begin
      san_hi = san_div - ONE;
    end
  end

  assign wrap = (cnt_q == div_q - ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    hi_d    = hi_q;
    pdiv_d  = pdiv_q;
    phi_d   = phi_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    ack_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (load) begin
          div_d  = san_div;
          hi_d   = san_hi;
          pend_d = 1'b0;
          ack_d  = 1'b1;
        end else if (pend_q) begin
          div_d  = pdiv_q;
          hi_d   = phi_q;
          pend_d = 1'b0;
          ack_d  = 1'b1;
        end
        if (en) begin
          state_d = RUN;
        end
      end

      RUN, STOP: begin
        clk_d = (cnt_q < hi_q);
        cnt_d = wrap ? '0 : cnt_q + ONE;
        if (wrap && pend_q) begin
          div_d  = pdiv_q;
          hi_d   = phi_q;
          pend_d = 1'b0;
          ack_d  = 1'b1;
        end
        // A load on the wrap edge waits for the following wrap.
        if (load) begin
          pdiv_d = san_div;
          phi_d  = san_hi;
          pend_d = 1'b1;
        end
        if (state_q == RUN) begin
          if (!en) begin
            state_d = STOP;
          end
        end else if (en) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= RST_D;
      hi_q    <= RST_H;
      pdiv_q  <= '0;
      phi_q   <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      pdiv_q  <= pdiv_d;
      phi_q   <= phi_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      ack_q   <= ack_d;
    end
  end

`ifdef CLK_DIV_PROG_STROBE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = clk_d & ~clk_q;
    fall_d = ~clk_d & clk_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_stb = rise_q;
  assign fall_stb = fall_q;
`else
  assign rise_stb = 1'b0;
  assign fall_stb = 1'b0;
`endif

  assign clk_out  = clk_q;
  assign load_ack = ack_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog.
// Strobe expectations follow CLK_DIV_PROG_STROBE_EN.
module tb_clk_div_prog;

`ifdef CLK_DIV_PROG_STROBE_EN
  localparam bit STB = 1'b1;
`else
  localparam bit STB = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b1;
  logic        en     = 1'b0;
  logic [15:0] div_in = '0;
  logic [15:0] hi_in  = '0;
  logic        load   = 1'b0;
  logic        load_ack;
  logic        busy;
  logic        clk_out;
  logic        rise_stb;
  logic        fall_stb;

  int n_cmp = 0;
  int n_err = 0;

  clk_div_prog #(.WIDTH(16), .RESET_DIV(16)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .div_in   (div_in),
    .hi_in    (hi_in),
    .load     (load),
    .load_ack (load_ack),
    .busy     (busy),
    .clk_out  (clk_out),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    #2;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", load_ack, 0);
    chk("rst_rise", rise_stb, 0);
    chk("rst_fall", fall_stb, 0);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_vals(int d, int h);
    div_in = 16'(d);
    hi_in  = 16'(h);
    load   = 1'b1;
  endtask

  // n edges of steady running; p0 is the count value used on the first edge.
  task automatic run_cyc(int n, int d, int h, int p0, bit ack1);
    for (int i = 0; i < n; i++) begin
      int p;
      p = (p0 + i) % d;
      tick();
      chk("clk_out", clk_out, 32'(p < h));
      chk("rise_stb", rise_stb, 32'(STB && p == 0));
      chk("fall_stb", fall_stb, 32'(STB && p == h));
      chk("load_ack", load_ack, 32'(ack1 && i == 0));
    end
  endtask

  initial begin
    // Defaults: period 16, high 8.
    do_reset();
    en = 1'b1;
    tick();
    chk("start_busy", busy, 1);
    chk("start_clk", clk_out, 0);
    run_cyc(40, 16, 8, 0, 1'b0);

    // Load in IDLE, then run 5/2.
    do_reset();
    load_vals(5, 2);
    tick();
    load = 1'b0;
    chk("idle_ack", load_ack, 1);
    chk("idle_busy", busy, 0);
    tick();
    chk("idle_ack_once", load_ack, 0);
    en = 1'b1;
    tick();
    chk("d5_busy", busy, 1);
    run_cyc(15, 5, 2, 0, 1'b0);

    // Two loads mid-period, single ack at the wrap.
    do_reset();
    load_vals(10, 5);
    tick();
    load = 1'b0;
    en   = 1'b1;
    tick();
    run_cyc(13, 10, 5, 0, 1'b0);
    load_vals(4, 1);
    run_cyc(1, 10, 5, 3, 1'b0);
    load = 1'b0;
    run_cyc(1, 10, 5, 4, 1'b0);
    load_vals(6, 3);
    run_cyc(1, 10, 5, 5, 1'b0);
    load = 1'b0;
    run_cyc(3, 10, 5, 6, 1'b0);
    run_cyc(1, 10, 5, 9, 1'b1);
    run_cyc(18, 6, 3, 0, 1'b0);

    // Sanitising: 0/0 -> 2/1, then 3/7 -> 3/2.
    do_reset();
    load_vals(0, 0);
    tick();
    load = 1'b0;
    chk("san_ack", load_ack, 1);
    en = 1'b1;
    tick();
    run_cyc(6, 2, 1, 0, 1'b0);
    load_vals(3, 7);
    run_cyc(1, 2, 1, 0, 1'b0);
    load = 1'b0;
    run_cyc(1, 2, 1, 1, 1'b1);
    run_cyc(9, 3, 2, 0, 1'b0);

    // Stop and restart without a gap, then a clean stop.
    do_reset();
    load_vals(8, 4);
    tick();
    load = 1'b0;
    en   = 1'b1;
    tick();
    run_cyc(2, 8, 4, 0, 1'b0);
    en = 1'b0;
    run_cyc(3, 8, 4, 2, 1'b0);
    chk("stop_busy", busy, 1);
    en = 1'b1;
    run_cyc(19, 8, 4, 5, 1'b0);
    en = 1'b0;
    run_cyc(7, 8, 4, 0, 1'b0);
    chk("stop_busy_pre", busy, 1);
    run_cyc(1, 8, 4, 7, 1'b0);
    chk("stop_busy_wrap", busy, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_clk", clk_out, 0);
      chk("idle_busy_hold", busy, 0);
    end

    // Reset while high with a pending load.
    do_reset();
    load_vals(6, 3);
    tick();
    load = 1'b0;
    en   = 1'b1;
    tick();
    run_cyc(2, 6, 3, 0, 1'b0);
    load_vals(4, 1);
    run_cyc(1, 6, 3, 2, 1'b0);
    load = 1'b0;
    chk("pre_rst_clk", clk_out, 1);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("async_clk", clk_out, 0);
    chk("async_busy", busy, 0);
    chk("async_ack", load_ack, 0);
    chk("async_rise", rise_stb, 0);
    chk("async_fall", fall_stb, 0);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    chk("rerun_busy", busy, 1);
    run_cyc(40, 16, 8, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider for the ADS8681 test FPGA, generating the converter-side serial and conversion clocks from `clk_in`. It replaces the fixed-divisor divider with a programmable period and high time, glitch-free start/stop, and boundary-synchronised reconfiguration. It also provides one-cycle edge strobes so downstream SPI logic can sample or launch on `clk_in` without using `clk_out` as a clock.

## Interface
- `WIDTH`, 16: width of counter, divisor and high-time fields.
- `RESET_DIV`, 16: divisor after reset. High time after reset is `RESET_DIV/2`.

- `clk_in`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request. Level sensitive.
- `div_in`  in  WIDTH  requested period D, in `clk_in` cycles.
- `hi_in`  in  WIDTH  requested high time H, in `clk_in` cycles.
- `load`  in  1  single-cycle strobe that captures `div_in` and `hi_in` as pending values.
- `load_ack`  out  1  single-cycle pulse when pending values become active.
- `busy`  out  1  high whenever state is not IDLE.
- `clk_out`  out  1  divided clock, registered.
- `rise_stb`  out  1  high in the cycle `clk_out` goes 0→1.
- `fall_stb`  out  1  high in the cycle `clk_out` goes 1→0.

## Operation
- Reset values:
  - Active D = `RESET_DIV`, active H = `RESET_DIV/2`.
  - `cnt` = 0, pending flag = 0, state = IDLE.
  - All outputs = 0.
- Sanitising on capture:
  - D < 2 is stored as 2.
  - H = 0 is stored as 1.
  - H ≥ D is stored as D−1.
  - The output therefore always toggles. Arithmetic is WIDTH-bit unsigned.
- States:
  - **IDLE**
    - `cnt` = 0, `clk_out` = 0.
    - `en` = 1 → RUN.
  - **RUN**
    - Each edge: `clk_out` <= (`cnt` < H).
    - `cnt` increments and wraps from D−1 to 0.
    - `en` = 0 → STOP.
  - **STOP**
    - Keeps counting exactly as in RUN.
    - At wrap (`cnt` = D−1) → IDLE with `cnt` = 0. No runt pulse is produced.
    - `en` = 1 before wrap → RUN, with no gap and no phase change.
- Load in IDLE: the new D and H take effect on the next edge, and `load_ack` pulses on that edge.
- Load in RUN or STOP:
  - Values are held as pending.
  - They are applied at the next wrap, when `cnt` = D−1 moves to 0.
  - `load_ack` pulses on that same edge.
- Repeated `load` before application: the latest values win, and exactly one `load_ack` is produced.
- `load` coinciding with a wrap edge: the values are captured as pending and applied at the following wrap, never mid-capture.
- Reset mid-operation: everything returns immediately (asynchronously) to the reset values and the pending load is discarded.

## Timing
- Start latency:
  - `en` sampled high in IDLE at edge k → RUN at k.
  - `clk_out` = 1 after edge k+1, with `rise_stb` = 1 in the same cycle.
- Steady state: period = D `clk_in` cycles; `clk_out` is high for H cycles and low for D−H cycles.
- Strobes are registered and coincide with the `clk_out` transition they report. Width is exactly one `clk_in` cycle.
- Stop: the final cycle of the period ends low. `busy` falls on the edge that enters IDLE.
- A reconfigured period starts with a high phase on the cycle after the wrap edge.

## Configuration
- `CLK_DIV_PROG_STROBE_EN` defined: `rise_stb` and `fall_stb` behave as specified above.
- `CLK_DIV_PROG_STROBE_EN` undefined:
  - `rise_stb` and `fall_stb` are tied to 0 and their edge-detect registers are removed.
  - All other behaviour is identical.

## Test plan
- Reset, then hold `en` = 1 with defaults → `clk_out` period 16, high 8. First rise 2 edges after `en` is sampled; `rise_stb` and `fall_stb` pulse once per period.
- In IDLE, load D = 5, H = 2, then `en` = 1 → `load_ack` 1 cycle after `load`; `clk_out` pattern 1,1,0,0,0 repeating.
- In RUN with D = 10, load D = 4, H = 1 mid-period, then load D = 6, H = 3 two cycles later → current period completes at 10 cycles; single `load_ack` at the wrap; next periods are 6 cycles with 3 high.
- Load D = 0, H = 0, then load D = 3, H = 7 → first load runs as D = 2, H = 1; second as D = 3, H = 2. `clk_out` toggles in both cases.
- `en` dropped at `cnt` = 2 of D = 8, re-raised at `cnt` = 5 → no gap, period stays 8. Dropped again and held → `busy` falls at wrap; `clk_out` stays 0.
- `rst_n` asserted while `clk_out` = 1 with a load pending → all outputs 0 immediately. After release, D = 16, H = 8 and no `load_ack` is produced.
